xc_aessub: RTL and testbench
============================

# xc_aessub

Lightweight AES SubBytes instruction unit; the substitution-layer companion to the MixColumns unit in the XCrypto AES datapath. Applies the forward AES S-box for encrypt or the inverse S-box for decrypt to four bytes gathered from two source registers. A single shared S-box is time-multiplexed over a 4-state counter, so each instruction completes in exactly 4 cycles.

## Interface

**Parameters**
- None.

**Ports**
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; clears in-flight state ready for the next instruction.
- `flush_data` in 32: value loaded into the byte registers on flush; only bits [7:0] are used.
- `valid` in 1: operands valid; held high with stable operands until `ready`.
- `rs1` in 32: source register 1.
- `rs2` in 32: source register 2.
- `enc` in 1: 1 selects the forward S-box (encrypt); 0 selects the inverse S-box (decrypt).
- `ready` out 1: instruction complete this cycle.
- `result` out 32: substituted word; valid only while `ready` is high.

## Operation

**Operand bytes**
- b0=`rs1[7:0]`, b1=`rs1[15:8]`, b2=`rs2[23:16]`, b3=`rs2[31:24]`.
- `result` = {S(b3), S(b2), S(b1), S(b0)}.
- S is the AES S-box when `enc`=1 and its inverse when `enc`=0.

**S-box core** (combinational, one instance)
- Forward: GF(2^8) inverse modulo 0x11b, with 0 mapping to 0, followed by the affine transform with constant 0x63.
- Inverse: inverse affine transform (constant 0x05), followed by the GF(2^8) inverse.
- Implemented as logic, not a ROM. Must match the FIPS-197 tables for all 256 inputs in both directions.

**State machine**
- 2-bit counter `fsm`, states 0..3. In state k the core input is byte bk.
- States 0, 1, 2: with `valid`, register S(bk) into byte register r_k, then advance to k+1.
- State 3: with `valid`, `ready`=1 and `result`={S(b3), r_2, r_1, r_0}, with S(b3) taken directly from the core. `fsm` wraps to 0 at the next edge.
- `valid` low: `fsm` and r_0..r_2 hold, and `ready`=0.

**Flush and reset**
- `flush`: at the next edge, `fsm`←0 and r_0..r_2←`flush_data[7:0]`. Flush wins over `valid` in the same cycle.
- `reset` low: immediately sets `fsm`=0 and r_0..r_2=0, independent of the clock.
- Reset asserted mid-instruction abandons it; the instruction restarts from state 0 after deassertion.

**Output gating**
- `ready` = `valid` && (`fsm`==3).
- `result` = 0 whenever `ready`=0.

**Operand rules**
- Operand or `enc` changes before `ready` give undefined `result`. The bench must not do this.

## Timing
- Reset values: `ready`=0, `result`=0x00000000, `fsm`=0.
- Latency: `valid` rises in cycle T with `fsm`=0 → `ready` is high in cycle T+3, combinationally, for exactly one cycle.
- Back-to-back: `valid` held high through T+3 with new operands presented from T+4 → the next `ready` is at T+7. There are no bubble cycles.
- Stall: each cycle of `valid` low between T and T+3 delays `ready` by one cycle.
- Flush in cycle T+1 of an instruction: no `ready` at T+3. If `valid` is still high, the instruction restarts at state 0 in T+2, and `ready` is at T+5.
- There is no combinational path from `flush` or `flush_data` to `ready` or `result`.

## Test plan
- Encrypt: `rs1`=0x00000100, `rs2`=0xff530000, `enc`=1, `valid` held high → `ready` only in cycle 4, `result`=0x16ed7c63. The outputs are 0 in cycles 1-3.
- Decrypt: `rs1`=0x00007c63, `rs2`=0x16ed0000, `enc`=0 → `result`=0xff530100 in cycle 4.
- Exhaustive: sweep all 256 values through each byte lane in both directions; compare against FIPS-197 tables. A round trip of inverse after forward must return the operand.
- Stall: encrypt of the first scenario with `valid` dropped for 2 cycles after state 1 → `ready` in cycle 6, `result`=0x16ed7c63.
- Flush: `flush`=1 with `flush_data`=0xa5 during state 2, `valid` held → no `ready` at the original cycle. The instruction restarts and returns the correct result 4 cycles after the flush edge.
- Async reset: drop `reset` mid-clock in state 2 → `fsm`=0 and `ready`=0 immediately. After release, a fresh encrypt returns 0x16ed7c63 after 4 cycles.

Source files
------------

// File: rtl/xc_aessub_if.sv
// Operand/result bundle for the AES SubBytes unit. The issuing pipeline is the
// master; the SubBytes unit is the slave.
interface xc_aessub_if;
    logic        flush;
    logic [31:0] flush_data;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] result;

    modport master (
        output flush, flush_data, valid, rs1, rs2, enc,
        input  ready, result
    );

    modport slave (
        input  flush, flush_data, valid, rs1, rs2, enc,
        output ready, result
    );
endinterface

// File: rtl/xc_aessub.sv
// xc_aessub: AES SubBytes instruction unit. One shared S-box is stepped over
// four byte lanes by a 2-bit state counter; each instruction takes 4 cycles.
//
// state | meaning
// ST_B0 | substituting rs1[7:0],   result stored in r_0
// ST_B1 | substituting rs1[15:8],  result stored in r_1
// ST_B2 | substituting rs2[23:16], result stored in r_2
// ST_B3 | substituting rs2[31:24], word presented with ready
module xc_aessub (
    input  logic       clock,
    input  logic       reset,
    xc_aessub_if.slave bus
);

    typedef enum logic [1:0] {
        ST_B0 = 2'd0,
        ST_B1 = 2'd1,
        ST_B2 = 2'd2,
        ST_B3 = 2'd3
    } state_t;

    state_t     fsm;
    state_t     fsm_nxt;
    logic       load;
    logic [7:0] r_0;
    logic [7:0] r_1;
    logic [7:0] r_2;
    logic [7:0] core_in;
    logic [7:0] inv_in;
    logic [7:0] inv_out;
    logic [7:0] core_out;
    logic       unused_bits;

    // Only the addressed byte of each operand feeds the datapath.
    assign unused_bits = ^{bus.flush_data[31:8], bus.rs1[31:16], bus.rs2[15:0]};

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); 0 maps to 0
    // naturally because every partial product stays 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    // Byte lane selection and the shared S-box; the field inverter is common
    // to both directions, only the affine stage moves around it.
    always_comb begin
        core_in = bus.rs1[7:0];
        case (fsm)
            ST_B0: core_in = bus.rs1[7:0];
            ST_B1: core_in = bus.rs1[15:8];
            ST_B2: core_in = bus.rs2[23:16];
            ST_B3: core_in = bus.rs2[31:24];
            default: core_in = bus.rs1[7:0];
        endcase
        inv_in   = bus.enc ? core_in : aff_inv(core_in);
        inv_out  = gf_inv(inv_in);
        core_out = bus.enc ? aff_fwd(inv_out) : inv_out;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) fsm <= ST_B0;
        else        fsm <= fsm_nxt;
    end

    // Next state, byte-register load enable and gated outputs.
    always_comb begin
        fsm_nxt    = fsm;
        load       = 1'b0;
        bus.ready  = 1'b0;
        bus.result = 32'h0;
        if (bus.flush) begin
            fsm_nxt = ST_B0;
        end else if (bus.valid) begin
            load    = (fsm != ST_B3);
            fsm_nxt = state_t'(fsm + 2'd1);
        end
        if (bus.valid && (fsm == ST_B3)) begin
            bus.ready  = 1'b1;
            bus.result = {core_out, r_2, r_1, r_0};
        end
    end

    // Partial result bytes; flush seeds them with flush_data[7:0].
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_0 <= 8'h00;
            r_1 <= 8'h00;
            r_2 <= 8'h00;
        end else if (bus.flush) begin
            r_0 <= bus.flush_data[7:0];
            r_1 <= bus.flush_data[7:0];
            r_2 <= bus.flush_data[7:0];
        end else if (load) begin
            case (fsm)
                ST_B0:   r_0 <= core_out;
                ST_B1:   r_1 <= core_out;
                ST_B2:   r_2 <= core_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_aessub.sv
// Bench for xc_aessub: a driver issues instructions and queues the expected
// word with the cycle it must appear in; a negedge monitor pops and compares.
module tb_xc_aessub;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    xc_aessub_if bus();

    xc_aessub dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    logic [7:0] fwd [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present operands with valid high for one full instruction; the expected
    // word must appear lat cycles after the presentation cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic e,
                         input logic [31:0] want, input int lat);
        exp_t x;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.enc   = e;
        bus.valid = 1'b1;
        x.res = want;
        x.at  = cyc + lat;
        q.push_back(x);
        repeat (4) tick();
    endtask

    always @(negedge clock) begin
        if (bus.ready === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: cycle %0d result %h, nothing queued", cyc, bus.result);
            end else begin
                mon_e = q.pop_front();
                check("result", bus.result, mon_e.res);
                check("ready_cycle", cyc, mon_e.at);
            end
        end else begin
            check("idle_result_zero", bus.result, 32'h0);
        end
    end

    initial begin
        logic [7:0]  x0, x1, x2, x3;
        logic [31:0] a, b;
        bus.flush      = 1'b0;
        bus.flush_data = 32'h0;
        bus.valid      = 1'b0;
        bus.rs1        = 32'h0;
        bus.rs2        = 32'h0;
        bus.enc        = 1'b0;

        #2;
        check("reset_ready", {31'h0, bus.ready}, 32'h0);
        check("reset_result", bus.result, 32'h0);
        check("reset_fsm", {30'h0, dut.fsm}, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Directed encrypt then decrypt.
        issue(32'h00000100, 32'hff530000, 1'b1, 32'h16ed7c63, 3);
        bus.valid = 1'b0;
        tick();
        issue(32'h00007c63, 32'h16ed0000, 1'b0, 32'hff530100, 3);
        bus.valid = 1'b0;
        tick();

        // Every byte value through every lane, back to back, both directions.
        // Decrypt operands are forward S-box outputs, so the expected word is
        // the original bytes (round trip).
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < 256; v++) begin
                x0 = v[7:0];
                x1 = v[7:0] ^ 8'h5a;
                x2 = v[7:0] + 8'd77;
                x3 = ~v[7:0];
                if (d == 0) begin
                    a = {16'($urandom), x1, x0};
                    b = {x3, x2, 16'($urandom)};
                    issue(a, b, 1'b1, {fwd[x3], fwd[x2], fwd[x1], fwd[x0]}, 3);
                end else begin
                    a = {16'($urandom), fwd[x1], fwd[x0]};
                    b = {fwd[x3], fwd[x2], 16'($urandom)};
                    issue(a, b, 1'b0, {x3, x2, x1, x0}, 3);
                end
            end
            bus.valid = 1'b0;
            tick();
        end

        // Stall: valid low for two cycles once state 2 is reached.
        begin
            exp_t x;
            bus.rs1 = 32'h00000100;
            bus.rs2 = 32'hff530000;
            bus.enc = 1'b1;
            bus.valid = 1'b1;
            x.res = 32'h16ed7c63;
            x.at  = cyc + 5;
            q.push_back(x);
            tick();
            tick();
            bus.valid = 1'b0;
            tick();
            tick();
            bus.valid = 1'b1;
            tick();
            tick();
            bus.valid = 1'b0;
            tick();
        end

        // Flush during state 2 with valid held: restart from state 0.
        begin
            exp_t x;
            bus.rs1 = 32'h00007c63;
            bus.rs2 = 32'h16ed0000;
            bus.enc = 1'b0;
            bus.valid = 1'b1;
            x.res = 32'hff530100;
            x.at  = cyc + 6;
            q.push_back(x);
            tick();
            tick();
            bus.flush      = 1'b1;
            bus.flush_data = 32'h123456a5;
            tick();
            bus.flush = 1'b0;
            check("flush_fsm", {30'h0, dut.fsm}, 32'h0);
            check("flush_r0", {24'h0, dut.r_0}, 32'h000000a5);
            check("flush_r1", {24'h0, dut.r_1}, 32'h000000a5);
            check("flush_r2", {24'h0, dut.r_2}, 32'h000000a5);
            repeat (4) tick();
            bus.valid = 1'b0;
            tick();
        end

        // Asynchronous reset in state 2, mid-cycle.
        bus.rs1 = 32'h00000100;
        bus.rs2 = 32'hff530000;
        bus.enc = 1'b1;
        bus.valid = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("async_fsm", {30'h0, dut.fsm}, 32'h0);
        check("async_ready", {31'h0, bus.ready}, 32'h0);
        check("async_r1", {24'h0, dut.r_1}, 32'h0);
        bus.valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        issue(32'h00000100, 32'hff530000, 1'b1, 32'h16ed7c63, 3);
        bus.valid = 1'b0;

        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected results never appeared", q.size());
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
